// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory controller slice:
//   - load/store opcode encodings (loads sort below OP_SB)
//   - IO region selector used by the optional IO stall (MEM_CTRL_IO_STALL_EN)
//   - load_extend(): sign/zero extension of an assembled little-endian word
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'd0;
  localparam logic [5:0] OP_LH  = 6'd1;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_LBU = 6'd3;
  localparam logic [5:0] OP_LHU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd5;
  localparam logic [5:0] OP_SH  = 6'd6;
  localparam logic [5:0] OP_SW  = 6'd7;

  // Byte addresses with addr[17:16] == IO_REGION belong to the UART.
  localparam logic [1:0] IO_REGION = 2'b11;

  // Extend the low len bytes of w to 32 bits (len is 1, 2 or 4).
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  len,
                                              input logic        sext);
    logic [31:0] r;
    case (len)
      3'd1:    r = sext ? {{24{w[7]}}, w[7:0]}   : {24'h0, w[7:0]};
      3'd2:    r = sext ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_ls_width_decode.sv
// -----------------------------------------------------------------------------
// mem_ctrl_ls_width_decode
// Combinational opcode decode for the load/store path.
// Ports:
//   opcode_i  load/store opcode
//   len_o     access width in bytes (1, 2 or 4)
//   sext_o    1 when the load result is sign-extended (LB, LH)
// -----------------------------------------------------------------------------
module mem_ctrl_ls_width_decode
  import mem_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [2:0] len_o,
  output logic       sext_o
);

  always_comb begin
    len_o  = 3'd4;
    sext_o = 1'b0;
    case (opcode_i)
      OP_LB:         begin len_o = 3'd1; sext_o = 1'b1; end
      OP_LBU, OP_SB: len_o = 3'd1;
      OP_LH:         begin len_o = 3'd2; sext_o = 1'b1; end
      OP_LHU, OP_SH: len_o = 3'd2;
      default:       len_o = 3'd4;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Serialises LSB load/store requests and instruction fetches onto a byte-wide
// RAM bus with one cycle of read latency. One response pulse per request.
// Ports:
//   clk, rst, rdy            clock, sync active-high reset, global enable
//   mem_valid/mem_ls/...     LSB request (held until mem_l_valid pulse)
//   mem_l_valid/mem_l_data   LSB response pulse and extended load data
//   if_valid/if_addr         fetch request (held until if_ready)
//   if_ready/if_data         fetch response pulse and instruction word
//   flush                    aborts an in-flight fetch only
//   mem_din/mem_dout/mem_a/mem_wr   RAM bus
//   io_buffer_full           UART full flag (used only with the IO stall)
// Optional build macro: MEM_CTRL_IO_STALL_EN -- stall writes into the IO
// region (addr[17:16]==2'b11) while io_buffer_full is set.
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              mem_valid,
  input  logic              mem_ls,
  input  logic [5:0]        mem_ls_opcode,
  input  logic [ADDR_W-1:0] mem_ls_addr,
  input  logic [31:0]       mem_s_data,
  output logic              mem_l_valid,
  output logic [31:0]       mem_l_data,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              flush,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, LS_READ, LS_WRITE, IF_READ} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;      // bytes stepped since acceptance
  logic [2:0]        len_q, len_d;
  logic              sext_q, sext_d;
  logic              pend_q, pend_d;    // current write byte held back (IO stall)
  logic [31:0]       data_q, data_d;    // store data, or load bytes collected so far
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              l_valid_q, l_valid_d;
  logic [31:0]       l_data_q, l_data_d;
  logic              if_ready_q, if_ready_d;
  logic [31:0]       if_data_q, if_data_d;

  logic [2:0]        dec_len;
  logic              dec_sext;
  logic [2:0]        cnt_nxt;
  logic [ADDR_W-1:0] mem_a_inc;
  logic [31:0]       merged;
  logic              stall_accept, stall_cur, stall_next;

  mem_ctrl_ls_width_decode u_dec (
    .opcode_i (mem_ls_opcode),
    .len_o    (dec_len),
    .sext_o   (dec_sext)
  );

  assign cnt_nxt   = cnt_q + 3'd1;
  assign mem_a_inc = mem_a_q + ADDR_W'(1);

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall_accept = io_buffer_full && (mem_ls_addr[17:16] == IO_REGION);
  assign stall_cur    = io_buffer_full && (mem_a_q[17:16] == IO_REGION);
  assign stall_next   = io_buffer_full && (mem_a_inc[17:16] == IO_REGION);
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign stall_accept   = 1'b0;
  assign stall_cur      = 1'b0;
  assign stall_next     = 1'b0;
`endif

  // Final read byte arrives on mem_din in the same cycle the response is
  // registered, so it is spliced in here rather than via data_q.
  always_comb begin
    merged = data_q;
    case (len_q)
      3'd1:    merged[7:0]   = mem_din;
      3'd2:    merged[15:8]  = mem_din;
      default: merged[31:24] = mem_din;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    sext_d     = sext_q;
    pend_d     = pend_q;
    data_d     = data_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    l_valid_d  = 1'b0;
    l_data_d   = l_data_q;
    if_ready_d = 1'b0;
    if_data_d  = if_data_q;

    case (state_q)
      IDLE: begin
        // No acceptance while a pulse is out: the requester is still
        // dropping its valid during that cycle.
        if (!l_valid_q && !if_ready_q) begin
          if (mem_valid) begin
            mem_a_d = mem_ls_addr;
            cnt_d   = 3'd0;
            len_d   = dec_len;
            sext_d  = dec_sext;
            if (mem_ls) begin
              state_d = LS_READ;
              data_d  = 32'h0;
            end else begin
              state_d    = LS_WRITE;
              data_d     = mem_s_data;
              mem_dout_d = mem_s_data[7:0];
              mem_wr_d   = !stall_accept;
              pend_d     = stall_accept;
            end
          end else if (if_valid && !flush) begin
            state_d = IF_READ;
            mem_a_d = if_addr;
            cnt_d   = 3'd0;
            len_d   = 3'd4;
            sext_d  = 1'b0;
            data_d  = 32'h0;
          end
        end
      end

      LS_READ, IF_READ: begin
        if (state_q == IF_READ && flush) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == len_q) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          if (state_q == LS_READ) begin
            l_valid_d = 1'b1;
            l_data_d  = load_extend(merged, len_q, sext_q);
          end else begin
            if_ready_d = 1'b1;
            if_data_d  = merged;
          end
        end else begin
          cnt_d = cnt_nxt;
          if (cnt_nxt < len_q) begin
            mem_a_d = mem_a_inc;
          end
          // Byte cnt-1 is on mem_din now (addressed two edges ago).
          case (cnt_q)
            3'd1:    data_d[7:0]   = mem_din;
            3'd2:    data_d[15:8]  = mem_din;
            3'd3:    data_d[23:16] = mem_din;
            default: ;
          endcase
        end
      end

      LS_WRITE: begin
        if (pend_q) begin
          // Same byte and address stay on the bus; only the strobe waits.
          if (!stall_cur) begin
            mem_wr_d = 1'b1;
            pend_d   = 1'b0;
          end
        end else if (cnt_nxt == len_q) begin
          state_d   = IDLE;
          cnt_d     = 3'd0;
          mem_wr_d  = 1'b0;
          l_valid_d = 1'b1;
        end else begin
          cnt_d   = cnt_nxt;
          mem_a_d = mem_a_inc;
          case (cnt_nxt)
            3'd1:    mem_dout_d = data_q[15:8];
            3'd2:    mem_dout_d = data_q[23:16];
            default: mem_dout_d = data_q[31:24];
          endcase
          mem_wr_d = !stall_next;
          pend_d   = stall_next;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      sext_q     <= 1'b0;
      pend_q     <= 1'b0;
      data_q     <= 32'h0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'h0;
      mem_wr_q   <= 1'b0;
      l_valid_q  <= 1'b0;
      l_data_q   <= 32'h0;
      if_ready_q <= 1'b0;
      if_data_q  <= 32'h0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      sext_q     <= sext_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      l_valid_q  <= l_valid_d;
      l_data_q   <= l_data_d;
      if_ready_q <= if_ready_d;
      if_data_q  <= if_data_d;
    end
  end

  assign mem_l_valid = l_valid_q;
  assign mem_l_data  = l_data_q;
  assign if_ready    = if_ready_q;
  assign if_data     = if_data_q;
  assign mem_dout    = mem_dout_q;
  assign mem_a       = mem_a_q;
  assign mem_wr      = mem_wr_q;

endmodule
